resilient_stage_ctrl: RTL and testbench

Synchronous, parametrised successor to the error-detecting stage controller. Runs one pipeline stage of a timing-resilient datapath: 4-phase Lreq/Lack handshake on the left and Rreq/Rack on the right. Captures a token into a main register, watches NUM_ERR error-detector lines during a sample window and takes a shadow copy at the window's end. On error it either replays from the shadow register with a cycle penalty or only reports the error, depending on mode.

---
 rtl/resilient_stage_ctrl_pkg.sv | 29 ++
 rtl/resilient_stage_ctrl_if.sv | 36 +++
 rtl/resilient_stage_ctrl_err_window.sv | 81 ++++++++
 rtl/resilient_stage_ctrl.sv | 135 +++++++++++++
 tb/tb_resilient_stage_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/resilient_stage_ctrl_pkg.sv
// resilient_pkg: shared types and helpers for the resilient stage controller.
//   state_e  - controller FSM states
//   Def*     - default parameter values
//   sat_inc  - saturating increment for counters up to 32 bits wide
package resilient_pkg;

  localparam int unsigned DefWidth   = 32;
  localparam int unsigned DefNumErr  = 2;
  localparam int unsigned DefWindow  = 2;
  localparam int unsigned DefPenalty = 1;
  localparam int unsigned DefCorrect = 1;
  localparam int unsigned DefCntW    = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWindow,
    StRecover,
    StSend,
    StRtz
  } state_e;

  // Increment val, but never beyond 2^width - 1.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/resilient_stage_ctrl_if.sv
// resilient_stage_ctrl_if: handshake, data and error-monitor signals of one stage.
//   Lreq/Lack/Ldata  - left 4-phase channel (Lreq, Ldata driven by the left peer)
//   Rreq/Rack/Rdata  - right 4-phase channel (Rack driven by the right peer)
//   Err              - error-detector flags
//   sample/err_evt/err_cnt - window-open, error-event pulse, saturating error count
// master: environment side; slave: the stage controller.
interface resilient_stage_ctrl_if
  import resilient_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NUM_ERR = DefNumErr,
  parameter int unsigned CNT_W   = DefCntW
) ();

  logic               Lreq;
  logic               Lack;
  logic [WIDTH-1:0]   Ldata;
  logic               Rreq;
  logic               Rack;
  logic [WIDTH-1:0]   Rdata;
  logic [NUM_ERR-1:0] Err;
  logic               sample;
  logic               err_evt;
  logic [CNT_W-1:0]   err_cnt;

  modport master (
    output Lreq, Ldata, Rack, Err,
    input  Lack, Rreq, Rdata, sample, err_evt, err_cnt
  );

  modport slave (
    input  Lreq, Ldata, Rack, Err,
    output Lack, Rreq, Rdata, sample, err_evt, err_cnt
  );

endinterface

// File: rtl/resilient_stage_ctrl_err_window.sv
// err_window: sample-window timing and error bookkeeping.
//   clk, rst     - clock, synchronous active-high reset
//   i_start      - token captured this cycle; restarts the window
//   i_active     - controller is in its window state
//   i_err        - error-detector flags
//   o_sample     - window open (detectors being sampled)
//   o_done       - last cycle of the window state
//   o_err_seen   - an error has been seen in this window (incl. this cycle)
//   o_err_evt    - one-cycle pulse after the window exit when an error was seen
//   o_err_cnt    - saturating count of error events
module err_window
  import resilient_pkg::*;
#(
  parameter int unsigned WINDOW  = DefWindow,
  parameter int unsigned NUM_ERR = DefNumErr,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_active,
  input  logic [NUM_ERR-1:0] i_err,
  output logic               o_sample,
  output logic               o_done,
  output logic               o_err_seen,
  output logic               o_err_evt,
  output logic [CNT_W-1:0]   o_err_cnt
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] LastCnt = CW'(WINDOW);

  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic             r_err, w_err_next;
  logic             r_evt, w_evt_next;
  logic [CNT_W-1:0] r_err_cnt, w_err_cnt_next;
  logic             w_err_now;

  // Count 0 is the cycle right after capture, while the captured data settles;
  // detectors are sampled on counts 1..WINDOW.
  assign o_sample   = i_active && (r_cnt != '0);
  assign o_done     = i_active && (r_cnt == LastCnt);
  assign w_err_now  = o_sample && (|i_err);
  assign o_err_seen = r_err || w_err_now;

  always_comb begin
    w_cnt_next     = r_cnt;
    w_err_next     = r_err;
    w_evt_next     = 1'b0;
    w_err_cnt_next = r_err_cnt;
    if (i_start) begin
      w_cnt_next = '0;
      w_err_next = 1'b0;
    end else if (i_active) begin
      if (!o_done) w_cnt_next = r_cnt + CW'(1);
      if (w_err_now) w_err_next = 1'b1;
    end
    if (o_done && o_err_seen) begin
      w_evt_next     = 1'b1;
      w_err_cnt_next = CNT_W'(sat_inc(32'(r_err_cnt), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_evt     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_err     <= w_err_next;
      r_evt     <= w_evt_next;
      r_err_cnt <= w_err_cnt_next;
    end
  end

  assign o_err_evt = r_evt;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/resilient_stage_ctrl.sv
// resilient_stage_ctrl: one timing-resilient pipeline stage.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of resilient_stage_ctrl_if (left/right 4-phase
//              handshakes, error flags, window/error status)
// A token is captured into the main register, error detectors are watched over
// the sample window and a shadow copy is taken at its end. On error the stage
// either replays from the shadow after a stall (CORRECT=1) or only reports it.
module resilient_stage_ctrl
  import resilient_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NUM_ERR = DefNumErr,
  parameter int unsigned WINDOW  = DefWindow,
  parameter int unsigned PENALTY = DefPenalty,
  parameter int unsigned CORRECT = DefCorrect,
  parameter int unsigned CNT_W   = DefCntW
) (
  input logic                 clk,
  input logic                 rst,
  resilient_stage_ctrl_if.slave bus
);

  localparam int unsigned PW = (PENALTY > 1) ? $clog2(PENALTY) : 1;
  localparam logic [PW-1:0] PenLast = PW'(PENALTY - 1);

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_main, w_main_next;
  logic [WIDTH-1:0] r_shadow, w_shadow_next;
  logic             r_lack, w_lack_next;
  logic             r_rreq, w_rreq_next;
  logic [PW-1:0]    r_pen, w_pen_next;
  logic             w_capture, w_in_window, w_send_enter;
  logic             w_sample, w_win_done, w_err_seen, w_err_evt;
  logic [CNT_W-1:0] w_err_cnt;

  // New capture only once both handshakes are back at zero.
  assign w_capture   = (r_state == StIdle) && bus.Lreq && !r_lack && !r_rreq && !bus.Rack;
  assign w_in_window = (r_state == StWindow);

  err_window #(
    .WINDOW  (WINDOW),
    .NUM_ERR (NUM_ERR),
    .CNT_W   (CNT_W)
  ) u_err_window (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_capture),
    .i_active   (w_in_window),
    .i_err      (bus.Err),
    .o_sample   (w_sample),
    .o_done     (w_win_done),
    .o_err_seen (w_err_seen),
    .o_err_evt  (w_err_evt),
    .o_err_cnt  (w_err_cnt)
  );

  always_comb begin
    w_state_next  = r_state;
    w_main_next   = r_main;
    w_shadow_next = r_shadow;
    w_rreq_next   = r_rreq;
    w_pen_next    = r_pen;
    w_send_enter  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_capture) begin
          w_state_next = StWindow;
          w_main_next  = bus.Ldata;
        end
      end
      StWindow: begin
        if (w_win_done) begin
          w_shadow_next = bus.Ldata;
          if (w_err_seen && (CORRECT != 0)) begin
            w_state_next = StRecover;
            w_pen_next   = '0;
          end else begin
            w_state_next = StSend;
            w_send_enter = 1'b1;
          end
        end
      end
      StRecover: begin
        if (r_pen == PenLast) begin
          w_state_next = StSend;
          w_main_next  = r_shadow;
          w_send_enter = 1'b1;
        end else begin
          w_pen_next = r_pen + PW'(1);
        end
      end
      StSend: begin
        if (bus.Rack) begin
          w_state_next = StRtz;
          w_rreq_next  = 1'b0;
        end
      end
      StRtz: begin
        if (!bus.Rack) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    if (w_send_enter) w_rreq_next = 1'b1;
    // Lack drops as soon as the left peer withdraws Lreq, whatever the state.
    if (r_lack && !bus.Lreq) w_lack_next = 1'b0;
    else if (w_send_enter)   w_lack_next = 1'b1;
    else                     w_lack_next = r_lack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_main   <= '0;
      r_shadow <= '0;
      r_lack   <= 1'b0;
      r_rreq   <= 1'b0;
      r_pen    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_main   <= w_main_next;
      r_shadow <= w_shadow_next;
      r_lack   <= w_lack_next;
      r_rreq   <= w_rreq_next;
      r_pen    <= w_pen_next;
    end
  end

  assign bus.Lack    = r_lack;
  assign bus.Rreq    = r_rreq;
  assign bus.Rdata   = r_main;
  assign bus.sample  = w_sample;
  assign bus.err_evt = w_err_evt;
  assign bus.err_cnt = w_err_cnt;

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Directed bench: dut_a uses default parameters (replay on error), dut_b is
// detect-only with a 2-bit error counter.
module tb_resilient_stage_ctrl;
  import resilient_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  resilient_stage_ctrl_if #(.WIDTH(32), .NUM_ERR(2), .CNT_W(8)) ifa ();
  resilient_stage_ctrl_if #(.WIDTH(32), .NUM_ERR(2), .CNT_W(2)) ifb ();

  resilient_stage_ctrl #(
    .WIDTH(32), .NUM_ERR(2), .WINDOW(2), .PENALTY(1), .CORRECT(1), .CNT_W(8)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  resilient_stage_ctrl #(
    .WIDTH(32), .NUM_ERR(2), .WINDOW(2), .PENALTY(1), .CORRECT(0), .CNT_W(2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int vectors = 0;
  int fails   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic rq, input logic lk, input logic [31:0] rd,
                       input logic sm, input logic ev, input logic [7:0] cn);
    chk({tag, ".a.Rreq"},    64'(ifa.Rreq),    64'(rq));
    chk({tag, ".a.Lack"},    64'(ifa.Lack),    64'(lk));
    chk({tag, ".a.Rdata"},   64'(ifa.Rdata),   64'(rd));
    chk({tag, ".a.sample"},  64'(ifa.sample),  64'(sm));
    chk({tag, ".a.err_evt"}, 64'(ifa.err_evt), 64'(ev));
    chk({tag, ".a.err_cnt"}, 64'(ifa.err_cnt), 64'(cn));
  endtask

  task automatic chk_b(input string tag, input logic rq, input logic lk, input logic [31:0] rd,
                       input logic sm, input logic ev, input logic [1:0] cn);
    chk({tag, ".b.Rreq"},    64'(ifb.Rreq),    64'(rq));
    chk({tag, ".b.Lack"},    64'(ifb.Lack),    64'(lk));
    chk({tag, ".b.Rdata"},   64'(ifb.Rdata),   64'(rd));
    chk({tag, ".b.sample"},  64'(ifb.sample),  64'(sm));
    chk({tag, ".b.err_evt"}, 64'(ifb.err_evt), 64'(ev));
    chk({tag, ".b.err_cnt"}, 64'(ifb.err_cnt), 64'(cn));
  endtask

  initial begin
    rst = 1'b1;
    ifa.Lreq = 1'b0; ifa.Ldata = '0; ifa.Rack = 1'b0; ifa.Err = '0;
    ifb.Lreq = 1'b0; ifb.Ldata = '0; ifb.Rack = 1'b0; ifb.Err = '0;
    tick();
    tick();
    chk_a("reset", 0, 0, 32'h0, 0, 0, 8'd0);
    chk_b("reset", 0, 0, 32'h0, 0, 0, 2'd0);
    rst = 1'b0;
    tick();

    // Clean token on A: Rreq three cycles after capture.
    ifa.Ldata = 32'hA5A5_0001; ifa.Lreq = 1'b1;
    tick();
    chk_a("clean.t0", 0, 0, 32'hA5A5_0001, 0, 0, 8'd0);
    tick();
    chk_a("clean.w1", 0, 0, 32'hA5A5_0001, 1, 0, 8'd0);
    tick();
    chk_a("clean.w2", 0, 0, 32'hA5A5_0001, 1, 0, 8'd0);
    tick();
    chk_a("clean.send", 1, 1, 32'hA5A5_0001, 0, 0, 8'd0);
    ifa.Lreq = 1'b0; ifa.Rack = 1'b1;
    tick();
    chk_a("clean.rtz", 0, 0, 32'hA5A5_0001, 0, 0, 8'd0);
    ifa.Rack = 1'b0;
    tick();
    chk("clean.idle", 64'(dut_a.r_state), 64'(StIdle));

    // Late data with an error in window cycle 2 on both DUTs.
    ifa.Ldata = 32'h1; ifa.Lreq = 1'b1;
    ifb.Ldata = 32'h1; ifb.Lreq = 1'b1;
    tick();
    chk_a("late.t0", 0, 0, 32'h1, 0, 0, 8'd0);
    chk_b("late.t0", 0, 0, 32'h1, 0, 0, 2'd0);
    ifa.Ldata = 32'h2; ifb.Ldata = 32'h2;
    tick();
    tick();
    ifa.Err = 2'b10; ifb.Err = 2'b10;
    tick();
    ifa.Err = 2'b00; ifb.Err = 2'b00;
    chk_a("late.recover", 0, 0, 32'h1, 0, 1, 8'd1);
    chk_b("late.send", 1, 1, 32'h1, 0, 1, 2'd1);
    ifb.Lreq = 1'b0; ifb.Rack = 1'b1;
    tick();
    chk_a("late.send", 1, 1, 32'h2, 0, 0, 8'd1);
    chk_b("late.rtz", 0, 0, 32'h1, 0, 0, 2'd1);
    chk("late.shadow_b", 64'(dut_b.r_shadow), 64'h2);
    ifb.Rack = 1'b0;
    ifa.Lreq = 1'b0; ifa.Rack = 1'b1;
    tick();
    chk_a("late.rtz", 0, 0, 32'h2, 0, 0, 8'd1);
    ifa.Rack = 1'b0;
    tick();
    chk("late.idle_a", 64'(dut_a.r_state), 64'(StIdle));
    chk("late.idle_b", 64'(dut_b.r_state), 64'(StIdle));

    // Err only just before capture and just after the window.
    ifa.Ldata = 32'h33; ifa.Lreq = 1'b1; ifa.Err = 2'b01;
    ifb.Ldata = 32'h33; ifb.Lreq = 1'b1; ifb.Err = 2'b01;
    tick();
    ifa.Err = 2'b00; ifb.Err = 2'b00;
    repeat (3) tick();
    ifa.Err = 2'b11; ifb.Err = 2'b11;
    chk_a("bnd.send", 1, 1, 32'h33, 0, 0, 8'd1);
    chk_b("bnd.send", 1, 1, 32'h33, 0, 0, 2'd1);
    ifa.Lreq = 1'b0; ifa.Rack = 1'b1;
    ifb.Lreq = 1'b0; ifb.Rack = 1'b1;
    tick();
    chk_a("bnd.after", 0, 0, 32'h33, 0, 0, 8'd1);
    chk_b("bnd.after", 0, 0, 32'h33, 0, 0, 2'd1);
    ifa.Err = 2'b00; ifa.Rack = 1'b0;
    ifb.Err = 2'b00; ifb.Rack = 1'b0;
    tick();

    // Back-pressure on A: Rack held low while Lreq toggles.
    ifa.Ldata = 32'h1234_5678; ifa.Lreq = 1'b1;
    repeat (4) tick();
    chk_a("bp.send", 1, 1, 32'h1234_5678, 0, 0, 8'd1);
    ifa.Lreq = 1'b0;
    tick();
    chk_a("bp.lack_rtz", 1, 0, 32'h1234_5678, 0, 0, 8'd1);
    for (int i = 0; i < 10; i++) begin
      ifa.Lreq  = (i % 2 == 0);
      ifa.Ldata = 32'hDEAD_0000 + 32'(i);
      tick();
      chk_a("bp.hold", 1, 0, 32'h1234_5678, 0, 0, 8'd1);
    end
    ifa.Lreq = 1'b0; ifa.Rack = 1'b1;
    tick();
    chk_a("bp.rtz", 0, 0, 32'h1234_5678, 0, 0, 8'd1);
    ifa.Rack = 1'b0;
    tick();
    chk("bp.idle", 64'(dut_a.r_state), 64'(StIdle));

    // Saturation on B: four more error tokens (five in total) with a 2-bit counter.
    for (int k = 0; k < 4; k++) begin
      ifb.Ldata = 32'h100 + 32'(k); ifb.Lreq = 1'b1; ifb.Err = 2'b01;
      repeat (4) tick();
      chk_b("sat.send", 1, 1, 32'h100 + 32'(k), 0, 1, (k == 0) ? 2'd2 : 2'd3);
      ifb.Err = 2'b00; ifb.Lreq = 1'b0; ifb.Rack = 1'b1;
      tick();
      ifb.Rack = 1'b0;
      tick();
    end
    chk_b("sat.final", 0, 0, 32'h103, 0, 0, 2'd3);

    // Reset during WINDOW.
    ifa.Ldata = 32'h77; ifa.Lreq = 1'b1;
    tick();
    tick();
    chk_a("rstwin.pre", 0, 0, 32'h77, 1, 0, 8'd1);
    rst = 1'b1;
    tick();
    chk_a("rstwin", 0, 0, 32'h0, 0, 0, 8'd0);
    chk_b("rstwin", 0, 0, 32'h0, 0, 0, 2'd0);
    rst = 1'b0; ifa.Lreq = 1'b0;
    tick();

    // Reset during RECOVER.
    ifa.Ldata = 32'h5; ifa.Lreq = 1'b1; ifa.Err = 2'b01;
    repeat (4) tick();
    chk_a("rstrec.pre", 0, 0, 32'h5, 0, 1, 8'd1);
    chk("rstrec.pre_state", 64'(dut_a.r_state), 64'(StRecover));
    rst = 1'b1; ifa.Err = 2'b00; ifa.Lreq = 1'b0;
    tick();
    chk_a("rstrec", 0, 0, 32'h0, 0, 0, 8'd0);
    chk("rstrec.shadow", 64'(dut_a.r_shadow), 64'h0);
    rst = 1'b0;
    tick();

    // Clean token after reset.
    ifa.Ldata = 32'h0BAD_F00D; ifa.Lreq = 1'b1;
    repeat (3) tick();
    chk_a("post.w2", 0, 0, 32'h0BAD_F00D, 1, 0, 8'd0);
    tick();
    chk_a("post.send", 1, 1, 32'h0BAD_F00D, 0, 0, 8'd0);
    ifa.Lreq = 1'b0; ifa.Rack = 1'b1;
    tick();
    chk_a("post.rtz", 0, 0, 32'h0BAD_F00D, 0, 0, 8'd0);
    ifa.Rack = 1'b0;
    tick();
    chk("post.idle", 64'(dut_a.r_state), 64'(StIdle));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
